// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared segment patterns, all-off constants and slot encoding
package seg_scan_pkg;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    SLOT_SEC0 = 2'd0,
    SLOT_SEC1 = 2'd1,
    SLOT_MIN0 = 2'd2,
    SLOT_MIN1 = 2'd3
  } slot_e;

endpackage

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - timer digits in, multiplexed display drive out
interface seg_scan_if;
  logic [3:0] minute1;
  logic [3:0] minute0;
  logic [3:0] second1;
  logic [3:0] second0;
  logic       finish;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output minute1, minute0, second1, second0, finish,
    input  seg, dp, an
  );

  modport slave (
    input  minute1, minute0, second1, second0, finish,
    output seg, dp, an
  );
endinterface

// File: rtl/seg_scan_bcd_to_seg.sv
// rtl/seg_scan_bcd_to_seg.sv - combinational BCD to active-low segment decoder
module bcd_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - 4-digit multiplexed display scanner with frame snapshot,
// dead-time, leading-zero blanking and finish blink
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEAD_CYC     = 500,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        clear_n,
  seg_scan_if.slave   bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_END  = PW'(DEAD_CYC);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]   presc_q, presc_d;
  slot_e           idx_q, idx_d;
  logic [3:0][3:0] snap_q, snap_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            phase_q, phase_d;
  logic            run_q, run_d;
  logic            armed_q, armed_d;
  logic            fin_prev_q, fin_prev_d;

  logic            tick;
  logic            frame_start;
  logic [3:0]      digit;
  logic [6:0]      dec_seg;
  logic            dead;
  logic            lz_blank;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      presc_q    <= '0;
      idx_q      <= SLOT_SEC0;
      snap_q     <= '0;
      fcnt_q     <= '0;
      phase_q    <= 1'b0;
      run_q      <= 1'b0;
      armed_q    <= 1'b0;
      // Starts high so a finish already high at release is not a rising edge
      fin_prev_q <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      fcnt_q     <= fcnt_d;
      phase_q    <= phase_d;
      run_q      <= run_d;
      armed_q    <= armed_d;
      fin_prev_q <= fin_prev_d;
    end
  end

  always_comb begin
    tick        = (presc_q == PRESC_MAX);
    presc_d     = tick ? '0 : presc_q + 1'b1;
    idx_d       = tick ? slot_e'(idx_q + 2'd1) : idx_q;
    frame_start = tick && (idx_q == SLOT_MIN1);
    snap_d      = frame_start ? {bus.minute1, bus.minute0, bus.second1, bus.second0}
                              : snap_q;
  end

  // The first frame start after a rising finish only arms the counter, so the
  // partial frame in progress never eats into the first visible half-period.
  always_comb begin
    fin_prev_d = bus.finish;
    run_d      = run_q;
    armed_d    = armed_q;
    fcnt_d     = fcnt_q;
    phase_d    = phase_q;
    if (!bus.finish) begin
      run_d   = 1'b0;
      armed_d = 1'b0;
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else begin
      if (!fin_prev_q) run_d = 1'b1;
      if (frame_start && run_q) begin
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (fcnt_q == FRAME_MAX) begin
          fcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
    end
  end

  assign digit = snap_q[idx_q];

  bcd_to_seg u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  always_comb begin
    dead     = (presc_q < DEAD_END);
    lz_blank = (idx_q == SLOT_MIN1) && (snap_q[3] == 4'd0);
    bus.an   = AN_OFF;
    bus.seg  = SEG_OFF;
    bus.dp   = 1'b1;
    if (!(dead || phase_q || lz_blank)) begin
      bus.an  = ~(4'b0001 << idx_q);
      bus.seg = dec_seg;
      bus.dp  = (idx_q != SLOT_MIN0);
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - scoreboard bench for seg_scan with SCAN_DIV=4, DEAD_CYC=1, BLINK_FRAMES=2
module tb_seg_scan;

  localparam int SD = 4;
  localparam int DC = 1;
  localparam int BF = 2;
  localparam int FRAME = SD * 4;
  localparam int NEVER = 1 << 30;
  localparam logic [11:0] ALL_OFF = {4'hF, 7'h7F, 1'b1};

  logic clk;
  logic clear_n;
  seg_scan_if bus();

  seg_scan #(.SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_FRAMES(BF)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests;
  int fails;
  int n;
  int blink_from;
  int fin_drop;
  logic [11:0] exp_q[$];
  logic [3:0]  dig[4];
  logic [3:0]  snap[4];
  logic        fin;
  logic [11:0] out;

  assign out = {bus.an, bus.seg, bus.dp};

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s n=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
               tag, n, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected outputs in cycle m counted from reset release
  function automatic logic [11:0] model(input int m);
    int presc, idx, f;
    bit dark;
    logic [3:0] an;
    presc = m % SD;
    idx   = (m / SD) % 4;
    f     = m / FRAME;
    dark  = (blink_from >= 0) && (m <= fin_drop) && (f >= blink_from) &&
            ((((f - blink_from) / BF) % 2) == 1);
    if (dark || presc < DC || (idx == 3 && snap[3] == 4'd0)) return ALL_OFF;
    an = 4'hF;
    an[idx] = 1'b0;
    return {an, dec(snap[idx]), (idx != 2)};
  endfunction

  task automatic drive();
    bus.minute1 = dig[3];
    bus.minute0 = dig[2];
    bus.second1 = dig[1];
    bus.second0 = dig[0];
    bus.finish  = fin;
  endtask

  task automatic apply_events(input int c);
    case (c)
      40:  begin dig[3] = 4'd0; dig[2] = 4'd5; end
      54:  dig[0] = 4'd7;
      70:  dig[1] = 4'hC;
      94:  begin fin = 1'b1; blink_from = (c + 2 + FRAME - 1) / FRAME; fin_drop = NEVER; end
      200: begin fin = 1'b0; fin_drop = c; end
      230: begin fin = 1'b1; blink_from = (c + 2 + FRAME - 1) / FRAME; fin_drop = NEVER; end
      default: ;
    endcase
    drive();
  endtask

  task automatic push_next(input int m);
    if (m % FRAME == 0 && m > 0) begin
      for (int i = 0; i < 4; i++) snap[i] = dig[i];
    end
    exp_q.push_back(model(m));
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 4; i++) snap[i] = 4'd0;
    blink_from = -1;
    fin_drop = NEVER;
    exp_q.delete();
    exp_q.push_back(model(0));
  endtask

  task automatic run(input int cycles, input bit events);
    for (int k = 0; k < cycles; k++) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty n=%0d", n);
      end else begin
        check_eq("scan", out, exp_q.pop_front());
      end
      if (events) apply_events(n);
      push_next(n + 1);
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    n = 0;
    fin = 1'b0;
    dig[3] = 4'd1; dig[2] = 4'd2; dig[1] = 4'd3; dig[0] = 4'd4;
    drive();
    clear_n = 1'b1;
    #1 clear_n = 1'b0;
    #1 check_eq("rst_async", out, ALL_OFF);
    repeat (3) @(negedge clk);
    check_eq("rst_hold", out, ALL_OFF);
    clear_n = 1'b1;
    model_reset();

    run(282, 1'b1);

    // Cycle 282: mid slot 2 of a dark blink frame
    check_eq("pre_rst", out, exp_q.pop_front());
    #2 clear_n = 1'b0;
    #1 check_eq("rst_async_mid", out, ALL_OFF);
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_mid", out, ALL_OFF);
    end
    clear_n = 1'b1;
    model_reset();

    run(48, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
